// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, index type and helpers for the round-robin stream mux
package mux_pkg;

  localparam int MUX_MAX_IN = 16;

  // Index width for n sources, never narrower than one bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Wide enough to hold any out_sel value a consumer may decode
  typedef logic [clog2_min1(MUX_MAX_IN)-1:0] idx_t;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// rtl/mux_rr_stream_rr_arbiter.sv - combinational round-robin arbiter with optional grant lock
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int IDX_W = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              lock,
  input  logic [IDX_W-1:0]  lock_idx,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic w_found;
  int   w_pos;

  // Search from ptr with wrap; a lock pins the grant to lock_idx whenever anyone requests
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_pos     = 0;
    if (lock) begin
      grant_idx = lock_idx;
      if (|req) grant[lock_idx] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        w_pos = int'(ptr) + k;
        if (w_pos >= NUM_IN) w_pos = w_pos - NUM_IN;
        if (!w_found && req[w_pos]) begin
          w_found       = 1'b1;
          grant[w_pos]  = 1'b1;
          grant_idx     = IDX_W'(w_pos);
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - NUM_IN-to-1 registered stream mux with round-robin arbitration (option: MUX_RR_PKT_LOCK_EN)
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int SIZE   = 5,
  parameter int NUM_IN = 4,
  localparam int IDX_W = clog2_min1(NUM_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_IN*SIZE-1:0] in_data,
  input  logic [NUM_IN-1:0]      in_valid,
  output logic [NUM_IN-1:0]      in_ready,
`ifdef MUX_RR_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]      in_last,
  output logic                   out_last,
`endif
  output logic [SIZE-1:0]        out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_sel
);

  out_state_e        r_state;
  out_state_e        w_state_nxt;
  logic              w_load_en;
  logic              w_out_valid;
  logic [NUM_IN-1:0] w_grant;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic              w_xfer;
  logic [SIZE-1:0]   w_grant_data;
  logic [SIZE-1:0]   r_out_data;
  logic [IDX_W-1:0]  r_out_sel;
  logic              w_lock;
  logic [IDX_W-1:0]  w_lock_idx;
  logic              w_advance;

`ifdef MUX_RR_PKT_LOCK_EN
  logic              r_lock;
  logic [IDX_W-1:0]  r_lock_idx;
  logic              r_out_last;

  assign w_lock     = r_lock;
  assign w_lock_idx = r_lock_idx;
  // Pointer moves only when a packet closes
  assign w_advance  = w_xfer && in_last[w_grant_idx];
  assign out_last   = r_out_last;
`else
  assign w_lock     = 1'b0;
  assign w_lock_idx = '0;
  assign w_advance  = w_xfer;
`endif

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .lock      (w_lock),
    .lock_idx  (w_lock_idx),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // No ready is offered while reset is held so nothing is consumed and then dropped
  assign in_ready     = (w_load_en && !rst) ? w_grant : '0;
  assign w_xfer       = |(in_valid & in_ready);
  assign w_grant_data = in_data[int'(w_grant_idx)*SIZE +: SIZE];
  assign w_ptr_nxt    = (int'(w_grant_idx) == NUM_IN - 1) ? '0 : w_grant_idx + IDX_W'(1);

  // Output register occupancy state
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Fill on any transfer; drain when the consumer takes the beat and nothing refills it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_xfer)         w_state_nxt = ST_FULL;
        else if (out_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // The register can take a new beat when empty or being emptied this cycle
  always_comb begin
    w_out_valid = (r_state == ST_FULL);
    w_load_en   = (r_state == ST_EMPTY) || out_ready;
  end

  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

  // Payload and source index; both hold unless a new beat is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_sel  <= '0;
    end else if (w_xfer) begin
      r_out_data <= w_grant_data;
      r_out_sel  <= w_grant_idx;
    end
  end

  // Round-robin pointer points one past the last winner
  always_ff @(posedge clk) begin
    if (rst)            r_rr_ptr <= '0;
    else if (w_advance) r_rr_ptr <= w_ptr_nxt;
  end

`ifdef MUX_RR_PKT_LOCK_EN
  // Hold the grant on the current source until its last beat is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_lock     <= !in_last[w_grant_idx];
      r_lock_idx <= w_grant_idx;
      r_out_last <= in_last[w_grant_idx];
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb/tb_mux_rr_stream.sv - directed self-checking bench for mux_rr_stream
module tb_mux_rr_stream;

  logic        clk;
  logic        rst;
  logic [19:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [4:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
`ifdef MUX_RR_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_cmp;
  int n_fail;

  mux_rr_stream #(.SIZE(5), .NUM_IN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_RR_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 4'b0000;
    tick();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", out_valid); end
    n_cmp++;
    if (out_data !== 5'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    n_cmp++;
    if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0h expected 0", out_sel); end
    n_cmp++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ready: got %b expected 0001", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'h10 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_beat: got v=%0h d=%0h s=%0h expected v=1 d=10 s=0", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_d;
    logic [1:0] exp_s;
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_s = 2'(k % 4);
      exp_d = 5'h10 + 5'(k % 4);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== exp_s) begin
        n_fail++;
        $display("FAIL rr_beat%0d: got v=%0h d=%0h s=%0h expected v=1 d=%0h s=%0h", k, out_valid, out_data, out_sel, exp_d, exp_s);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if (out_data !== 5'h12) begin n_fail++; $display("FAIL bp_setup: got %0h expected 12", out_data); end
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 0000", k, in_ready); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 5'h12 || out_sel !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%0h d=%0h s=%0h expected v=1 d=12 s=2", k, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1000", in_ready); end
    tick();
    n_cmp++;
    if (out_data !== 5'h13 || out_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_release_beat: got d=%0h s=%0h expected d=13 s=3", out_data, out_sel);
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    tick();
    in_valid = 4'b1010;
    #1;
    n_cmp++;
    if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_ready_ch3: got %b expected 1000", in_ready); end
    tick();
    n_cmp++;
    if (out_data !== 5'h13 || out_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL sparse_beat_ch3: got d=%0h s=%0h expected d=13 s=3", out_data, out_sel);
    end
    n_cmp++;
    if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_ready_ch1: got %b expected 0010", in_ready); end
    tick();
    n_cmp++;
    if (out_data !== 5'h11 || out_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL sparse_beat_ch1: got d=%0h s=%0h expected d=11 s=1", out_data, out_sel);
    end
    in_valid = 4'b1111;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL sparse_ptr_end: got %b expected 0100", in_ready); end
    in_valid = 4'b0000;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 5'h11) begin
      n_fail++;
      $display("FAIL sparse_drain: got v=%0h d=%0h expected v=0 d=11", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'h11) begin
      n_fail++;
      $display("FAIL mid_full: got v=%0h d=%0h expected v=1 d=11", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0000", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 5'h00 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_rst_out: got v=%0h d=%0h s=%0h expected v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_ready: got %b expected 0001", in_ready); end
    tick();
    n_cmp++;
    if (out_data !== 5'h10 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_restart_beat: got d=%0h s=%0h expected d=10 s=0", out_data, out_sel);
    end
  endtask

`ifdef MUX_RR_PKT_LOCK_EN
  task automatic test_pkt_lock();
    logic [1:0] exp_s [4];
    logic       exp_l [4];
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd1};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      in_last = (k == 2) ? 4'b0001 : ((k == 3) ? 4'b0010 : 4'b0000);
      #1;
      n_cmp++;
      if (in_ready !== ((k == 3) ? 4'b0010 : 4'b0001)) begin
        n_fail++;
        $display("FAIL lock_ready%0d: got %b expected %b", k, in_ready, ((k == 3) ? 4'b0010 : 4'b0001));
      end
      tick();
      n_cmp++;
      if (out_sel !== exp_s[k] || out_last !== exp_l[k]) begin
        n_fail++;
        $display("FAIL lock_beat%0d: got s=%0h l=%0h expected s=%0h l=%0h", k, out_sel, out_last, exp_s[k], exp_l[k]);
      end
    end
    in_last  = 4'b0000;
    in_valid = 4'b0001;
    tick();
    n_cmp++;
    if (out_sel !== 2'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_reacquire: got s=%0h l=%0h expected s=0 l=0", out_sel, out_last);
    end
    in_valid = 4'b0010;
    #1;
    n_cmp++;
    if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL lock_idle_block: got %b expected bit1=0", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lock_idle_drain: got %0h expected 0", out_valid); end
    in_last  = 4'b1111;
    in_valid = 4'b0001;
    tick();
    n_cmp++;
    if (out_sel !== 2'd0 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_release: got s=%0h l=%0h expected s=0 l=1", out_sel, out_last);
    end
    in_valid = 4'b0000;
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    in_data   = {5'h13, 5'h12, 5'h11, 5'h10};
`ifdef MUX_RR_PKT_LOCK_EN
    in_last   = 4'b1111;
`endif
    #2;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_reset_mid();
`ifdef MUX_RR_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
